// File: rtl/sram_page_allocator.sv
// ---------------------------------------------------------------------------
// sram_page_allocator
//
// Free-page manager for one SRAM bank. The write side pops one page number
// per batch and the read side returns released pages. There is no sweep at
// reset. Pages that were never used come from an ascending fresh counter.
// Released pages go back into circulation through a BRAM FIFO.
//
// Allocation order: all fresh pages first (0 .. PAGE_NUM-1). After that,
// recycled pages are handed out in the exact order they were released.
//
// A two-entry prefetch stage sits between the BRAM read port and the
// show-ahead output register. It hides the one-cycle BRAM read latency, so
// back-to-back pops can run at one per cycle. When the BRAM FIFO is empty,
// a released page skips the BRAM: it goes into the prefetch stage, or
// straight to alloc_page. This keeps the refill latency short when the pool
// is almost empty.
//
// Ports
//   clk            in   1       clock, all logic on rising edge
//   rst            in   1       synchronous reset, active-high
//   alloc_req      in   1       pop: consume alloc_page this cycle
//   alloc_vld      out  1       alloc_page holds an allocatable page
//   alloc_page     out  ADDR_W  page offered to the writer (show-ahead)
//   free_req       in   1       push: return free_page to the pool
//   free_page      in   ADDR_W  page being released
//   free_count     out  CNT_W   pages currently free (incl. alloc_page)
//   underflow_err  out  1       1-cycle pulse: pop while alloc_vld=0
//   overflow_err   out  1       1-cycle pulse: push while pool is full
// ---------------------------------------------------------------------------
module sram_page_allocator #(
    parameter int PAGE_NUM = 2048,
    parameter int ADDR_W   = $clog2(PAGE_NUM),
    parameter int CNT_W    = ADDR_W + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              alloc_req,
    output logic              alloc_vld,
    output logic [ADDR_W-1:0] alloc_page,
    input  logic              free_req,
    input  logic [ADDR_W-1:0] free_page,
    output logic [CNT_W-1:0]  free_count,
    output logic              underflow_err,
    output logic              overflow_err
);

    localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(PAGE_NUM);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(PAGE_NUM - 1);

    // Registered state
    logic [CNT_W-1:0]  fresh_ptr_q,  fresh_ptr_d;   // next never-used page
    logic [ADDR_W-1:0] head_q,       head_d;        // BRAM FIFO read index
    logic [ADDR_W-1:0] tail_q,       tail_d;        // BRAM FIFO write index
    logic [CNT_W-1:0]  bram_cnt_q,   bram_cnt_d;    // entries not yet read out
    logic [ADDR_W-1:0] pf_q [2];                    // prefetch stage, [0] oldest
    logic [ADDR_W-1:0] pf_d [2];
    logic [1:0]        pf_cnt_q,     pf_cnt_d;
    logic              rd_vld_q,     rd_vld_d;      // rd_data_q valid this cycle
    logic              alloc_vld_q,  alloc_vld_d;
    logic [ADDR_W-1:0] alloc_page_q, alloc_page_d;
    logic [CNT_W-1:0]  free_count_q, free_count_d;
    logic              underflow_q,  underflow_d;
    logic              overflow_q,   overflow_d;

    // BRAM
    logic [ADDR_W-1:0] mem [PAGE_NUM];
    logic [ADDR_W-1:0] rd_data_q;
    logic              mem_we;
    logic              rd_en;

    // Combinational helpers
    logic              pop_ok;
    logic              push_ok;
    logic              refill;
    logic              fresh_done;
    logic              bram_empty;
    logic              bypass;
    logic              take_list;
    logic [ADDR_W-1:0] lst [3];      // ordered candidates: prefetch, read data, bypass
    logic [1:0]        lst_n;

    // NOTE: every signal assigned in this always_comb gets a default value
    // first. Without the defaults, a path that skips an assignment would
    // infer a latch.
    always_comb begin
        pop_ok     = alloc_req && alloc_vld_q;
        push_ok    = free_req && (free_count_q != FULL_CNT);
        refill     = !alloc_vld_q || pop_ok;   // output slot is free after this edge
        fresh_done = (fresh_ptr_q == FULL_CNT);
        bram_empty = (bram_cnt_q == '0);

        // Collect recycled pages in release order: the prefetch entries
        // first, then the BRAM word that arrives this cycle. Prefetch
        // entries plus the in-flight read never exceed two, so the read
        // data lands in slot 0 or 1.
        lst[0] = pf_q[0];
        lst[1] = pf_q[1];
        lst[2] = '0;
        lst_n  = pf_cnt_q;
        if (rd_vld_q) begin
            if (pf_cnt_q == 2'd0) begin
                lst[0] = rd_data_q;
            end else begin
                lst[1] = rd_data_q;
            end
            lst_n = lst_n + 2'd1;
        end

        // A released page may skip the BRAM only while the BRAM holds
        // nothing older. It must also fit in the prefetch stage after this
        // edge's refill.
        bypass = push_ok && bram_empty &&
                 !((lst_n == 2'd2) && !(refill && fresh_done));
        if (bypass) begin
            case (lst_n)
                2'd0:    lst[0] = free_page;
                2'd1:    lst[1] = free_page;
                default: lst[2] = free_page;
            endcase
            lst_n = lst_n + 2'd1;
        end

        // Recycled pages are handed out only after the fresh counter runs out.
        take_list = refill && fresh_done && (lst_n != 2'd0);

        pf_d[0]  = take_list ? lst[1] : lst[0];
        pf_d[1]  = take_list ? lst[2] : lst[1];
        pf_cnt_d = lst_n - {1'b0, take_list};

        // Start a BRAM read whenever the prefetch stage has room for the
        // word after this edge. Pushes that skip the BRAM happen only when
        // it is empty, and no read starts then, so the two never collide.
        rd_en    = !bram_empty && (pf_cnt_d != 2'd2);
        rd_vld_d = rd_en;
        mem_we   = push_ok && !bypass;

        head_d = head_q;
        if (rd_en) begin
            head_d = (head_q == LAST_IDX) ? '0 : head_q + ADDR_W'(1);
        end
        tail_d = tail_q;
        if (mem_we) begin
            tail_d = (tail_q == LAST_IDX) ? '0 : tail_q + ADDR_W'(1);
        end
        bram_cnt_d = bram_cnt_q + CNT_W'(mem_we) - CNT_W'(rd_en);

        // Show-ahead output register. A consumed page is dropped at once,
        // so alloc_vld never stays high for a page the writer has taken.
        alloc_vld_d  = alloc_vld_q && !pop_ok;
        alloc_page_d = alloc_page_q;
        fresh_ptr_d  = fresh_ptr_q;
        if (refill && !fresh_done) begin
            alloc_vld_d  = 1'b1;
            alloc_page_d = fresh_ptr_q[ADDR_W-1:0];
            fresh_ptr_d  = fresh_ptr_q + CNT_W'(1);
        end else if (take_list) begin
            alloc_vld_d  = 1'b1;
            alloc_page_d = lst[0];
        end

        free_count_d = free_count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
        underflow_d  = alloc_req && !alloc_vld_q;
        overflow_d   = free_req && (free_count_q == FULL_CNT);
    end

    // NOTE: sequential state uses non-blocking assignments only. Each flop
    // then samples its _d value from before the edge, whatever order the
    // statements are written in.
    always_ff @(posedge clk) begin
        if (rst) begin
            fresh_ptr_q  <= '0;
            head_q       <= '0;
            tail_q       <= '0;
            bram_cnt_q   <= '0;
            pf_q[0]      <= '0;
            pf_q[1]      <= '0;
            pf_cnt_q     <= 2'd0;
            rd_vld_q     <= 1'b0;
            alloc_vld_q  <= 1'b0;
            alloc_page_q <= '0;
            free_count_q <= FULL_CNT;
            underflow_q  <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            fresh_ptr_q  <= fresh_ptr_d;
            head_q       <= head_d;
            tail_q       <= tail_d;
            bram_cnt_q   <= bram_cnt_d;
            pf_q[0]      <= pf_d[0];
            pf_q[1]      <= pf_d[1];
            pf_cnt_q     <= pf_cnt_d;
            rd_vld_q     <= rd_vld_d;
            alloc_vld_q  <= alloc_vld_d;
            alloc_page_q <= alloc_page_d;
            free_count_q <= free_count_d;
            underflow_q  <= underflow_d;
            overflow_q   <= overflow_d;
        end
    end

    // NOTE: the storage array and its read register are not reset. That
    // lets them map onto block RAM. Nothing reads a word before it has
    // been written, and rd_vld_q masks the read register after reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[tail_q] <= free_page;
        end
        if (rd_en) begin
            rd_data_q <= mem[head_q];
        end
    end

    assign alloc_vld     = alloc_vld_q;
    assign alloc_page    = alloc_page_q;
    assign free_count    = free_count_q;
    assign underflow_err = underflow_q;
    assign overflow_err  = overflow_q;

endmodule
